// File: rtl/dip_scan_controller.sv
// ---------------------------------------------------------------------------
// dip_scan_controller
//
// Sequencer for a 16-bit serial DIP-switch chain built from parallel-in /
// serial-out shift registers. Each scan pulses the active-low latch, clocks
// the 16 bits out of the chain MSB-first, and then compares the scan with
// the previous one. A value is accepted only after STABLE_SCANS identical
// consecutive scans, and only if it differs from the value already shown.
//
// Parameters
//   CLK_DIV       system clocks per half-period of the shift clock / latch
//   STABLE_SCANS  identical consecutive scans needed before acceptance
//
// Ports
//   i_CLK       system clock, rising edge
//   i_RESET     synchronous active-high reset
//   i_Enable    run continuous scans while high
//   i_Data      serial data from the chain
//   i_Ack       clears o_Changed (an accept in the same cycle wins)
//   o_DIP_CLK   shift clock to the chain, idles low
//   o_DIPLatch  active-low parallel-load strobe, idles high
//   o_DIP16     last accepted switch value
//   o_Valid     a value has been accepted since reset
//   o_Changed   sticky "o_DIP16 updated" flag
//   o_Busy      FSM is not idle
// ---------------------------------------------------------------------------
module dip_scan_controller #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned STABLE_SCANS = 3
) (
   input  logic        i_CLK,
   input  logic        i_RESET,
   input  logic        i_Enable,
   input  logic        i_Data,
   input  logic        i_Ack,
   output logic        o_DIP_CLK,
   output logic        o_DIPLatch,
   output logic [15:0] o_DIP16,
   output logic        o_Valid,
   output logic        o_Changed,
   output logic        o_Busy
);

   // Counter spans one full slot (2*CLK_DIV cycles); at least 1 bit wide.
   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam int unsigned RUN_W = (STABLE_SCANS > 1) ? $clog2(STABLE_SCANS + 1) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(STABLE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_COMPARE = 2'd3
   } state_e;

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [3:0]         bit_q,     bit_d;
   logic [15:0]        shift_q,   shift_d;
   logic [15:0]        prev_q,    prev_d;
   logic [RUN_W-1:0]   run_q,     run_d;
   logic               seen_q,    seen_d;
   logic [15:0]        dip_q,     dip_d;
   logic               valid_q,   valid_d;
   logic               changed_q, changed_d;
   logic               dclk_q,    dclk_d;
   logic               latch_q,   latch_d;
   logic               busy_q,    busy_d;
   logic               accept;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      prev_d  = prev_q;
      run_d   = run_q;
      seen_d  = seen_q;
      dip_d   = dip_q;
      valid_d = valid_q;
      accept  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (i_Enable) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (cnt_q == SLOT_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_SHIFT: begin
            // Sample on the last low cycle; the shift clock rises on the
            // same edge. Shifting left leaves the first bit in bit 15.
            if (cnt_q == HALF_LAST) begin
               shift_d = {shift_q[14:0], i_Data};
            end
            if (cnt_q == SLOT_LAST) begin
               cnt_d = '0;
               if (bit_q == 4'd15) begin
                  state_d = ST_COMPARE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_COMPARE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!seen_q || (shift_q != prev_q)) begin
               run_d = RUN_W'(1);
            end else if (run_q >= RUN_MAX) begin
               run_d = RUN_MAX;
            end else begin
               run_d = run_q + 1'b1;
            end
            prev_d = shift_q;
            seen_d = 1'b1;

            accept = (run_d == RUN_MAX) && (!valid_q || (shift_q != dip_q));
            if (accept) begin
               dip_d   = shift_q;
               valid_d = 1'b1;
            end

            state_d = i_Enable ? ST_LOAD : ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase

      // Set has priority over acknowledge.
      if (accept) begin
         changed_d = 1'b1;
      end else if (i_Ack) begin
         changed_d = 1'b0;
      end else begin
         changed_d = changed_q;
      end

      // Chain-facing outputs are decoded from the next state so that the
      // registered versions line up exactly with the state they belong to.
      dclk_d  = (state_d == ST_SHIFT) && (cnt_d > HALF_LAST);
      latch_d = (state_d != ST_LOAD);
      busy_d  = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         prev_q    <= '0;
         run_q     <= '0;
         seen_q    <= 1'b0;
         dip_q     <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
         dclk_q    <= 1'b0;
         latch_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         seen_q    <= seen_d;
         dip_q     <= dip_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         dclk_q    <= dclk_d;
         latch_q   <= latch_d;
         busy_q    <= busy_d;
      end
   end

   assign o_DIP_CLK  = dclk_q;
   assign o_DIPLatch = latch_q;
   assign o_DIP16    = dip_q;
   assign o_Valid    = valid_q;
   assign o_Changed  = changed_q;
   assign o_Busy     = busy_q;

endmodule

// File: doc/dip_scan_controller.md
# dip_scan_controller

Sequencer for the board's 16-bit serial DIP-switch chain (parallel-in/serial-out shift registers). It generates the chain's load (latch) and shift clock from the system clock, deserializes the 16 bits, filters switch bounce by requiring consecutive identical scans, and presents a stable 16-bit value with a change flag and acknowledge handshake to the CPU side.

## Interface
- `CLK_DIV`, default 4: `i_CLK` cycles per half-period of `o_DIP_CLK` and of the latch pulse; legal range is ≥1.
- `STABLE_SCANS`, default 3: number of consecutive identical scans required before a value is accepted; legal range is ≥1 (1 means every scan is accepted).
- `i_CLK`, in, 1: system clock. All logic is on its rising edge.
- `i_RESET`, in, 1: synchronous, active-high reset.
- `i_Enable`, in, 1: continuous scanning runs while this is high.
- `i_Data`, in, 1: serial output of the DIP chain.
- `i_Ack`, in, 1: clears `o_Changed`.
- `o_DIP_CLK`, out, 1: shift clock to the chain. Idles low.
- `o_DIPLatch`, out, 1: parallel-load strobe, active-low. Idles high.
- `o_DIP16`, out, 16: last accepted (debounced) switch value.
- `o_Valid`, out, 1: high once any value has been accepted since reset.
- `o_Changed`, out, 1: sticky flag meaning "`o_DIP16` updated". Held until acknowledged.
- `o_Busy`, out, 1: high when the FSM is not in IDLE.

## Operation
- FSM states are IDLE, LOAD, SHIFT and COMPARE. All outputs are registered.
- IDLE → LOAD when `i_Enable` is high. IDLE holds while `i_Enable` is low.
- **LOAD:**
  - `o_DIPLatch` is 0 for 2·CLK_DIV cycles, with `o_DIP_CLK` held at 0.
  - Then go to SHIFT with bit index 0.
- **SHIFT:** 16 bit slots, each 2·CLK_DIV cycles long.
  - First half of the slot: `o_DIP_CLK`=0. Second half: `o_DIP_CLK`=1.
  - `i_Data` is sampled on the last cycle of the low half, just before the rising edge.
  - The first sampled bit goes to bit 15 (MSB-first). Bit k of the slot count goes to bit 15−k.
  - After slot 15, go to COMPARE.
- **COMPARE:** lasts 1 cycle.
  - If this is the first scan since reset, or the scan differs from the previous scan, set `run`=1. Otherwise set `run`=min(run+1, STABLE_SCANS).
  - The scan is stored as the previous scan.
  - **Accept** when `run`==STABLE_SCANS and (`o_Valid`==0 or scan≠`o_DIP16`). On accept:
    - `o_DIP16` ← scan
    - `o_Valid` ← 1
    - `o_Changed` ← 1
  - Next state is LOAD if `i_Enable` is high, else IDLE.
- **`o_Changed`:**
  - Cleared by `i_Ack`=1 in any cycle without an accept.
  - An accept and `i_Ack` in the same cycle leave it at 1 (the set wins).
- **`i_Enable` dropped mid-scan:** the current scan runs to COMPARE, its result is used, then the FSM goes to IDLE.
- **Reset (any state, mid-scan included):**
  - FSM goes to IDLE, and the shift register, previous scan, `run` and first-scan flag are cleared.
  - Outputs: `o_DIP_CLK`=0, `o_DIPLatch`=1, `o_DIP16`=16'h0000, `o_Valid`=0, `o_Changed`=0, `o_Busy`=0.
  - A partial scan is discarded and is never compared.

## Timing
- Scan period is 34·CLK_DIV+1 cycles: LOAD 2·CLK_DIV, SHIFT 32·CLK_DIV, COMPARE 1. With the default this is 137 cycles.
- IDLE→LOAD costs 1 cycle. `o_DIPLatch` falls on the cycle after the FSM leaves IDLE.
- `o_DIP16`, `o_Valid` and `o_Changed` change on the edge that ends COMPARE.
- Latency from first enable to first accept: 1 + STABLE_SCANS·(34·CLK_DIV+1) cycles. With the defaults this is 412.
- A switch change takes at most STABLE_SCANS+1 scans to appear, once it is stable.
- In continuous mode COMPARE → LOAD back-to-back: `o_DIPLatch` goes low the cycle after COMPARE.

## Test plan
- **Static pattern.** Chain model holds 16'hA5C3, `i_Enable`=1 from reset release, defaults.
  - `o_DIP16`=16'hA5C3, `o_Valid`=1 and `o_Changed`=1 exactly at cycle 412.
  - `o_DIP_CLK` shows 16 pulses per scan, each high for 4 cycles.
- **Bounce.** Chain alternates 16'h0001 / 16'h0000 on successive scans, then holds 16'h0001.
  - No accept while it alternates.
  - Accept of 16'h0001 after 3 equal scans.
  - A later repeat of the same stable value raises no new `o_Changed`.
- **Handshake.** Pulse `i_Ack` after an accept: `o_Changed` falls the next cycle.
  - `i_Ack` asserted in the same cycle as a new accept: `o_Changed` stays 1 and `o_DIP16` updates.
- **Enable drop.** Deassert `i_Enable` mid-SHIFT of scan 3.
  - Scan 3 completes and is accepted (16'hA5C3).
  - Then IDLE with `o_Busy`=0, `o_DIP_CLK`=0 and `o_DIPLatch`=1.
- **Reset mid-scan.** Assert `i_RESET` for 1 cycle during SHIFT bit 7.
  - All outputs take their reset values the next cycle.
  - The next accept needs a full 3 scans and occurs 412 cycles after reset release.
- **Parameter corners.** CLK_DIV=1, STABLE_SCANS=1: the scan period is 35 cycles and every differing scan is accepted.
